alarm_sequencer: RTL and testbench

- Downstream stage of the keypad/passcode block. Consumes its `is_enabled` level (correct passcode toggles arm/disarm) and the raw `is_breach` sensor line.
- Sequences exit delay, armed watch, entry delay, timed siren and post-siren hold.
- Drives the siren, a latched authorities alert, and a blinking status LED.
- Replaces the keypad's immediate breach-to-alert path with a timed, disarm-able sequence.

---
 rtl/alarm_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
//
// Timed alarm sequencing stage that sits behind the keypad/passcode block.
// Arming starts an exit delay. A breach while armed starts an entry delay
// that can still be disarmed. After that the siren sounds for a fixed time,
// then a silenced hold follows that re-alarms on a fresh breach edge.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   is_enabled        arm request level from the keypad block (clk domain)
//   is_breach         raw, asynchronous sensor line
//   armed             high in ARMED, ENTRY, ALARM, SILENCED
//   siren             high only in ALARM
//   alert_authorities latched from first ALARM entry until DISARMED
//   status_led        off when disarmed, on when armed, blinking otherwise
//   state             current state code (debug / test)
// ---------------------------------------------------------------------------
module alarm_sequencer #(
    parameter int CNT_W       = 8,
    parameter int EXIT_DELAY  = 16,
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 32,
    parameter int BLINK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_enabled,
    input  logic       is_breach,
    output logic       armed,
    output logic       siren,
    output logic       alert_authorities,
    output logic       status_led,
    output logic [2:0] state
);

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;
    localparam logic [2:0] ST_SILENCED = 3'd5;

    // The counter holds "cycles remaining minus one", so a load of N-1 gives
    // exactly N cycles in the state.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

    localparam int               BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               breach_meta_q;
    logic               breach_s_q;
    logic               breach_prev_q;   // breach_s one cycle earlier, for edge detect
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               armed_q, armed_d;
    logic               siren_q, siren_d;
    logic               alert_q, alert_d;
    logic               led_q, led_d;

    // Next-state and delay counter. Disarm is checked first so it wins over
    // every expiry or breach in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != ST_DISARMED && !is_enabled) begin
            state_d = ST_DISARMED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (is_enabled) begin
                        state_d = ST_EXIT;
                        cnt_d   = EXIT_LOAD;
                    end
                end
                ST_EXIT: begin
                    if (cnt_q == '0) state_d = ST_ARMED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_ARMED: begin
                    if (breach_s_q) begin
                        state_d = ST_ENTRY;
                        cnt_d   = ENTRY_LOAD;
                    end
                end
                ST_ENTRY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                ST_ALARM: begin
                    if (cnt_q == '0) state_d = ST_SILENCED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_SILENCED: begin
                    // Only a fresh rising edge re-alarms; a held line does not.
                    if (breach_s_q && !breach_prev_q) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Blink generator restarts on every state change so each blinking state
    // begins with the LED low.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (state_d != state_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register.
    always_comb begin
        armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY) ||
                  (state_d == ST_ALARM) || (state_d == ST_SILENCED);
        siren_d = (state_d == ST_ALARM);
        alert_d = alert_q;
        if (state_d == ST_DISARMED)   alert_d = 1'b0;
        else if (state_d == ST_ALARM) alert_d = 1'b1;
        case (state_d)
            ST_ARMED:                                   led_d = 1'b1;
            ST_EXIT, ST_ENTRY, ST_ALARM, ST_SILENCED:   led_d = blink_phase_d;
            default:                                    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DISARMED;
            cnt_q         <= '0;
            breach_meta_q <= 1'b0;
            breach_s_q    <= 1'b0;
            breach_prev_q <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            armed_q       <= 1'b0;
            siren_q       <= 1'b0;
            alert_q       <= 1'b0;
            led_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            breach_meta_q <= is_breach;
            breach_s_q    <= breach_meta_q;
            breach_prev_q <= breach_s_q;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            armed_q       <= armed_d;
            siren_q       <= siren_d;
            alert_q       <= alert_d;
            led_q         <= led_d;
        end
    end

    assign state             = state_q;
    assign armed             = armed_q;
    assign siren             = siren_q;
    assign alert_authorities = alert_q;
    assign status_led        = led_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alarm_sequencer
//
// Scoreboard bench. The driver applies stimulus, advances a time-based
// reference model on each rising edge and queues the expected outputs. A
// separate monitor pops one entry per falling edge and compares it against
// the DUT outputs.
// ---------------------------------------------------------------------------
module tb_alarm_sequencer;

    localparam int EXIT_DELAY  = 16;
    localparam int ENTRY_DELAY = 8;
    localparam int SIREN_TIME  = 32;
    localparam int BLINK_DIV   = 4;

    localparam int S_DISARMED = 0;
    localparam int S_EXIT     = 1;
    localparam int S_ARMED    = 2;
    localparam int S_ENTRY    = 3;
    localparam int S_ALARM    = 4;
    localparam int S_SILENCED = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       is_enabled = 1'b0;
    logic       is_breach = 1'b0;
    logic       armed, siren, alert_authorities, status_led;
    logic [2:0] state;

    alarm_sequencer #(
        .CNT_W      (8),
        .EXIT_DELAY (EXIT_DELAY),
        .ENTRY_DELAY(ENTRY_DELAY),
        .SIREN_TIME (SIREN_TIME),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .is_enabled       (is_enabled),
        .is_breach        (is_breach),
        .armed            (armed),
        .siren            (siren),
        .alert_authorities(alert_authorities),
        .status_led       (status_led),
        .state            (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       armed;
        logic       siren;
        logic       alert;
        logic       led;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: state name, cycles spent in it, alarm-seen flag and a
    // short history of the sensor line (two-cycle synchronizer delay).
    int   m_st = S_DISARMED;
    int   m_el = 0;
    bit   m_alert = 1'b0;
    bit   h0 = 1'b0, h1 = 1'b0, h_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic en, input logic br);
        int   nxt;
        exp_t e;
        cyc++;
        if (rst) begin
            m_st = S_DISARMED; m_el = 0; m_alert = 1'b0;
            h0 = 1'b0; h1 = 1'b0; h_prev = 1'b0;
        end else begin
            nxt = m_st;
            if (m_st != S_DISARMED && !en) nxt = S_DISARMED;
            else if (m_st == S_DISARMED && en) nxt = S_EXIT;
            else if (m_st == S_EXIT && m_el == EXIT_DELAY - 1) nxt = S_ARMED;
            else if (m_st == S_ARMED && h1) nxt = S_ENTRY;
            else if (m_st == S_ENTRY && m_el == ENTRY_DELAY - 1) nxt = S_ALARM;
            else if (m_st == S_ALARM && m_el == SIREN_TIME - 1) nxt = S_SILENCED;
            else if (m_st == S_SILENCED && h1 && !h_prev) nxt = S_ALARM;
            m_el = (nxt != m_st) ? 0 : m_el + 1;
            m_st = nxt;
            if (m_st == S_DISARMED) m_alert = 1'b0;
            else if (m_st == S_ALARM) m_alert = 1'b1;
            h_prev = h1; h1 = h0; h0 = br;
        end
        e.st    = 3'(m_st);
        e.armed = (m_st >= S_ARMED);
        e.siren = (m_st == S_ALARM);
        e.alert = m_alert;
        if (m_st == S_ARMED) e.led = 1'b1;
        else if (m_st == S_DISARMED) e.led = 1'b0;
        else e.led = ((m_el / BLINK_DIV) % 2) == 1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic br);
        @(negedge clk);
        is_enabled = en;
        is_breach  = br;
        @(posedge clk);
        model_edge(en, br);
    endtask

    task automatic run_until(input int st, input int el, input logic en,
                             input logic br, input int limit);
        int n;
        n = 0;
        while (!(m_st == st && m_el == el) && n < limit) begin
            step(en, br);
            n++;
        end
        total++;
        if (!(m_st == st && m_el == el)) begin
            bad++;
            $display("FAIL reach_state cycle=%0d got=%0d/%0d expected=%0d/%0d",
                     cyc, m_st, m_el, st, el);
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic async_reset_check();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_armed", int'(armed), 0);
        check("async_rst_siren", int'(siren), 0);
        check("async_rst_alert", int'(alert_authorities), 0);
        check("async_rst_led",   int'(status_led), 0);
        exp_q.delete();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #1 rst = 1'b0;
    endtask

    // Monitor: one expected entry per rising edge, compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",  int'(state), int'(e.st));
            check("armed",  int'(armed), int'(e.armed));
            check("siren",  int'(siren), int'(e.siren));
            check("alert",  int'(alert_authorities), int'(e.alert));
            check("led",    int'(status_led), int'(e.led));
        end
    end

    initial begin
        logic br;
        int   len;
        int   off;

        // Power-on reset, then idle disarmed.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #1 rst = 1'b0;
        repeat (3) step(1'b0, 1'b0);

        // Arm, glitch is_enabled low for one cycle, re-arm with full delay.
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (EXIT_DELAY + 4) step(1'b1, 1'b0);

        // Breach while armed, then disarm partway through ENTRY.
        run_until(S_ENTRY, 3, 1'b1, 1'b1, 100);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Full alarm, disarm on the very edge the siren would expire.
        run_until(S_ALARM, 0, 1'b1, 1'b1, 100);
        run_until(S_ALARM, SIREN_TIME - 1, 1'b1, 1'b0, 100);
        step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        // Re-trigger: held breach into SILENCED does nothing, a new edge does.
        run_until(S_SILENCED, 0, 1'b1, 1'b1, 200);
        repeat (5) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        run_until(S_ALARM, 0, 1'b1, 1'b1, 4);
        repeat (SIREN_TIME + 3) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Reset asserted in the middle of ALARM.
        run_until(S_ALARM, 5, 1'b1, 1'b1, 200);
        async_reset_check();
        repeat (3) step(1'b0, 1'b0);

        // Randomized arming episodes with a wandering sensor line.
        br = 1'b0;
        for (int ep = 0; ep < 40; ep++) begin
            len = $urandom_range(10, 140);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 7) == 0) br = ~br;
                step(1'b1, br);
            end
            off = $urandom_range(1, 3);
            for (int c = 0; c < off; c++) begin
                if ($urandom_range(0, 7) == 0) br = ~br;
                step(1'b0, br);
            end
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
